hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS core. Decides each cycle whether the front end (PC, IF/ID) stalls, whether a bubble enters ID/EXE, whether IF/ID is flushed on a taken branch, and whether the whole pipeline freezes while data memory is not ready. It sits beside the forwarding unit:

- With `forwardEn`=1, it inserts only the load-use bubble that forwarding cannot cover.
- With `forwardEn`=0, it stalls on every RAW dependence.
- It also keeps saturating stall/flush statistics and a memory-timeout error flag.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: consecutive not-ready memory cycles before the error state. Range 1..65535.

Ports. The block uses one clock, and its reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `forwardEn`  in  1  1 = forwarding datapath active
- `idSrc1`, `idSrc2`  in  5 each  source registers of the instruction in ID
- `idTwoSrc`  in  1  1 = ID instruction reads `idSrc2` (R-type, store, bne/beq)
- `exeRegDst`  in  5  destination register in EXE
- `exeWbEn`  in  1  EXE instruction writes back
- `exeMemRead`  in  1  EXE instruction is a load
- `memRegDst`  in  5  destination register in MEM
- `memWbEn`  in  1  MEM instruction writes back
- `branchTaken`  in  1  branch resolved taken (EXE)
- `memReq`  in  1  MEM stage is accessing data memory
- `memReady`  in  1  data memory completes access this cycle
- `cntClr`  in  1  synchronous clear of statistics counters
- `pcStall`  out  1  hold PC
- `ifIdStall`  out  1  hold IF/ID
- `idExeBubble`  out  1  load NOP into ID/EXE
- `ifIdFlush`  out  1  load NOP into IF/ID
- `freeze`  out  1  hold every pipeline register
- `memTimeout`  out  1  sticky error
- `state`  out  2  FSM state (debug)
- `stallCycles`  out  16  saturating count of data-hazard stall cycles
- `flushCount`  out  16  saturating count of taken-branch flushes

## Operation

**Data hazard detection**
- A source matches a destination only when `src == dst`, `dst != 0`, and the destination's `WbEn` = 1.
- `idSrc2` is considered only when `idTwoSrc` = 1.
- `forwardEn`=1: `hazard` = an EXE match AND `exeMemRead`. A MEM match never stalls.
- `forwardEn`=0: `hazard` = an EXE match OR a MEM match. The register file is write-first, so WB needs no check.

**FSM states**
- RUN=0: normal operation.
- MEM_WAIT=1: memory access in progress.
- ERROR=2: memory timeout.

**FSM transitions**
- RUN → MEM_WAIT when `memReq` && !`memReady`.
- MEM_WAIT → RUN when `memReady`, or when `memReq` drops.
- MEM_WAIT → ERROR when `waitCnt` == `MEM_TIMEOUT`-1 && `memReq` && !`memReady`.
- ERROR is left only by reset.

**`waitCnt`**
- 16 bits.
- Increments on every cycle with `memReq` && !`memReady`.
- Cleared to 0 otherwise.

**Output priority** (highest first)
1. `freeze` = (`memReq` && !`memReady`) || state==ERROR. When `freeze`=1, all other control outputs are 0.
2. `branchTaken`: `ifIdFlush`=1 and `idExeBubble`=1, no stall. The ID instruction is wrong-path, so its hazard is ignored.
3. `hazard`: `pcStall`=`ifIdStall`=`idExeBubble`=1.
4. Otherwise, all control outputs are 0.

**Counters**
- `stallCycles` +1 in each cycle where priority 3 is active.
- `flushCount` +1 in each cycle where priority 2 is active.
- Both saturate at 0xFFFF.
- `cntClr` takes precedence over increment.

**`memTimeout`**
- `memTimeout` = (state==ERROR), registered.

## Timing
- Control outputs (`pcStall`, `ifIdStall`, `idExeBubble`, `ifIdFlush`, `freeze`) are combinational from inputs and state, valid in the same cycle.
- `state`, `waitCnt`, counters and `memTimeout` update on the rising edge.

**Reset** (while `rst_n`=0)
- state=RUN, `waitCnt`=0, `stallCycles`=0, `flushCount`=0, `memTimeout`=0.
- All control outputs are forced 0.
- A reset asserted mid-stall or mid-wait drops everything immediately.

**Latency**
- A load-use dependence with forwarding costs exactly 1 bubble. The next cycle the load is in MEM, so the hazard clears.
- Without forwarding, a dependence costs up to 2 stall cycles.

**Boundary cases**
- Timeout: with `MEM_TIMEOUT`=N and continuous not-ready, state becomes ERROR after the N-th edge of waiting.
- `memReady` in the same cycle the timeout would trigger: ready wins, and the FSM returns to RUN.
- Freeze and hazard in the same cycle: counters do not increment. The hazard is re-evaluated after the freeze lifts.
- `forwardEn` may change on any cycle and takes effect combinationally.

## Structure
- Shared package `mips_hazard_pkg`:
  - state enum (RUN, MEM_WAIT, ERROR)
  - register-index width (5)
  - counter width (16)
- One sub-module, `sat_counter16`: clear/increment/saturate, instantiated twice (stall and flush counters).

## Test plan
- **Load-use with forwarding:** `forwardEn`=1, `exeMemRead`=1, `exeWbEn`=1, `exeRegDst`=5, `idSrc1`=5 for one cycle → `pcStall`=`ifIdStall`=`idExeBubble`=1 for 1 cycle, and `stallCycles` 0→1.
- **No forwarding, MEM match, $0 excluded:** `forwardEn`=0, `memRegDst`=7, `memWbEn`=1, `idSrc2`=7, `idTwoSrc`=1 → stall. Repeat with `memRegDst`=0 and `idSrc2`=0 → no stall.
- **Flush beats hazard:** `branchTaken`=1 together with a load-use match → `ifIdFlush`=1, `idExeBubble`=1, `pcStall`=0, `flushCount`+1, `stallCycles` unchanged.
- **Memory wait:** `memReq`=1 with `memReady`=0 for 3 cycles, then 1 → `freeze`=1 for 3 cycles, state goes RUN→MEM_WAIT→RUN, `waitCnt` back to 0, and concurrent hazards are suppressed.
- **Timeout:** `MEM_TIMEOUT`=4 with `memReady` held 0 → state=ERROR and `memTimeout`=1 after the 4th edge. `freeze` stays 1 after `memReq` drops. `rst_n` pulse → all outputs 0, state RUN.
- **Saturation and clear:** drive 65,537 hazard cycles → `stallCycles`=0xFFFF held. Then `cntClr`=1 together with a hazard → 0.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types and widths for the MIPS hazard/sequencing controller.
// Holds the FSM state encoding, field widths and the register-match helper.
package mips_hazard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hzState_e;

  // Register $0 is hard-wired to zero, so a write to it never creates a dependence.
  function automatic logic srcMatch(input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst,
                                    input logic             wbEn);
    return wbEn && (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline-status inputs and sequencing outputs of the hazard controller.
// The master side is the pipeline that reports status; the slave side is the controller.
interface hazard_controller_if;
  import mips_hazard_pkg::*;

  logic             forwardEn;
  logic [REG_W-1:0] idSrc1;
  logic [REG_W-1:0] idSrc2;
  logic             idTwoSrc;
  logic [REG_W-1:0] exeRegDst;
  logic             exeWbEn;
  logic             exeMemRead;
  logic [REG_W-1:0] memRegDst;
  logic             memWbEn;
  logic             branchTaken;
  logic             memReq;
  logic             memReady;
  logic             cntClr;

  logic             pcStall;
  logic             ifIdStall;
  logic             idExeBubble;
  logic             ifIdFlush;
  logic             freeze;
  logic             memTimeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output forwardEn, idSrc1, idSrc2, idTwoSrc, exeRegDst, exeWbEn, exeMemRead,
           memRegDst, memWbEn, branchTaken, memReq, memReady, cntClr,
    input  pcStall, ifIdStall, idExeBubble, ifIdFlush, freeze, memTimeout,
           state, stallCycles, flushCount
  );

  modport slave (
    input  forwardEn, idSrc1, idSrc2, idTwoSrc, exeRegDst, exeWbEn, exeMemRead,
           memRegDst, memWbEn, branchTaken, memReq, memReady, cntClr,
    output pcStall, ifIdStall, idExeBubble, ifIdFlush, freeze, memTimeout,
           state, stallCycles, flushCount
  );

endinterface

// File: rtl/hazard_controller_sat_counter16.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter16
  import mips_hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/bubble/flush/freeze sequencing for the 5-stage MIPS pipeline, with
// memory-wait FSM, timeout error and saturating stall/flush statistics.
module hazard_controller
  import mips_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
)(
  input  logic                clk,
  input  logic                rst_n,
  hazard_controller_if.slave  hzBus
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  hzState_e    state_q;
  logic [15:0] waitCnt_q;
  logic        memTimeout_q;

  logic exeMatch;
  logic memMatch;
  logic hazard;
  logic memStall;
  logic timeoutHit;
  logic freezeAct;
  logic flushAct;
  logic stallAct;

  always_comb begin
    exeMatch = srcMatch(hzBus.idSrc1, hzBus.exeRegDst, hzBus.exeWbEn) ||
               (hzBus.idTwoSrc && srcMatch(hzBus.idSrc2, hzBus.exeRegDst, hzBus.exeWbEn));
    memMatch = srcMatch(hzBus.idSrc1, hzBus.memRegDst, hzBus.memWbEn) ||
               (hzBus.idTwoSrc && srcMatch(hzBus.idSrc2, hzBus.memRegDst, hzBus.memWbEn));
    // With forwarding only a load in EXE is too late to bypass; without it any producer stalls.
    hazard     = hzBus.forwardEn ? (exeMatch && hzBus.exeMemRead) : (exeMatch || memMatch);
    memStall   = hzBus.memReq && !hzBus.memReady;
    timeoutHit = (waitCnt_q == TIMEOUT_LAST);
    freezeAct  = memStall || (state_q == ERROR);
    flushAct   = !freezeAct && hzBus.branchTaken;
    stallAct   = !freezeAct && !hzBus.branchTaken && hazard;
  end

  // The RUN branch also checks the timeout so that MEM_TIMEOUT=1 errors on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      waitCnt_q    <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      waitCnt_q <= memStall ? (waitCnt_q + 16'd1) : 16'd0;
      case (state_q)
        RUN: begin
          if (memStall) begin
            if (timeoutHit) begin
              state_q      <= ERROR;
              memTimeout_q <= 1'b1;
            end else begin
              state_q <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (!memStall) begin
            state_q <= RUN;
          end else if (timeoutHit) begin
            state_q      <= ERROR;
            memTimeout_q <= 1'b1;
          end
        end
        ERROR: begin
          memTimeout_q <= 1'b1;
        end
        default: begin
          state_q      <= RUN;
          memTimeout_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter16 u_stallCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (hzBus.cntClr),
    .inc_i   (stallAct),
    .count_o (hzBus.stallCycles)
  );

  sat_counter16 u_flushCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (hzBus.cntClr),
    .inc_i   (flushAct),
    .count_o (hzBus.flushCount)
  );

  // Control outputs are gated by reset so an asserted reset silences them immediately.
  assign hzBus.freeze      = rst_n && freezeAct;
  assign hzBus.ifIdFlush   = rst_n && flushAct;
  assign hzBus.idExeBubble = rst_n && (flushAct || stallAct);
  assign hzBus.pcStall     = rst_n && stallAct;
  assign hzBus.ifIdStall   = rst_n && stallAct;
  assign hzBus.memTimeout  = memTimeout_q;
  assign hzBus.state       = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (MEM_TIMEOUT=4).
module tb_hazard_controller;
  import mips_hazard_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if hzBus ();

  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hzBus (hzBus)
  );

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
    logic        mto;
  } exp_t;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b00001;

  exp_t        sbQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  logic [15:0] expStall    = 16'd0;
  logic [15:0] expFlush    = 16'd0;
  logic [4:0]  ctrlObs;

  assign ctrlObs = {hzBus.pcStall, hzBus.ifIdStall, hzBus.idExeBubble,
                    hzBus.ifIdFlush, hzBus.freeze};

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    assertCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clearInputs();
    hzBus.forwardEn   = 1'b0;
    hzBus.idSrc1      = '0;
    hzBus.idSrc2      = '0;
    hzBus.idTwoSrc    = 1'b0;
    hzBus.exeRegDst   = '0;
    hzBus.exeWbEn     = 1'b0;
    hzBus.exeMemRead  = 1'b0;
    hzBus.memRegDst   = '0;
    hzBus.memWbEn     = 1'b0;
    hzBus.branchTaken = 1'b0;
    hzBus.memReq      = 1'b0;
    hzBus.memReady    = 1'b0;
    hzBus.cntClr      = 1'b0;
  endtask

  task automatic loadUse();
    hzBus.exeMemRead = 1'b1;
    hzBus.exeWbEn    = 1'b1;
    hzBus.exeRegDst  = 5'd5;
    hzBus.idSrc1     = 5'd5;
  endtask

  // Expected control pattern and post-edge state are given; counters follow from them.
  task automatic applyStimulus(input logic [4:0] ctrl, input logic [1:0] st, input logic mto);
    exp_t e;
    if (hzBus.cntClr) begin
      expStall = 16'd0;
      expFlush = 16'd0;
    end else begin
      if (ctrl == C_STALL && expStall != 16'hFFFF) expStall = expStall + 16'd1;
      if (ctrl == C_FLUSH && expFlush != 16'hFFFF) expFlush = expFlush + 16'd1;
    end
    e.ctrl  = ctrl;
    e.st    = st;
    e.stall = expStall;
    e.flush = expFlush;
    e.mto   = mto;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sbQ.pop_front();
      #1;
      checkVal({tag, ".ctrl"}, 16'(ctrlObs), 16'(e.ctrl));
      @(posedge clk);
      #1;
      checkVal({tag, ".state"}, 16'(hzBus.state), 16'(e.st));
      checkVal({tag, ".stall"}, hzBus.stallCycles, e.stall);
      checkVal({tag, ".flush"}, hzBus.flushCount, e.flush);
      checkVal({tag, ".mto"}, 16'(hzBus.memTimeout), 16'(e.mto));
    end
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    hzBus.forwardEn = 1'b1;
    loadUse();
    hzBus.memReq = 1'b1;
    #2;
    checkVal("rst.ctrl", 16'(ctrlObs), 16'(C_NONE));
    checkVal("rst.state", 16'(hzBus.state), 16'(RUN));
    checkVal("rst.stall", hzBus.stallCycles, 16'd0);
    checkVal("rst.flush", hzBus.flushCount, 16'd0);
    checkVal("rst.mto", 16'(hzBus.memTimeout), 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    clearInputs();
    $display("[TB] load-use and RAW detection");

    hzBus.forwardEn = 1'b1;
    loadUse();
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("loadUseFwd");

    hzBus.exeMemRead = 1'b0;
    hzBus.exeWbEn    = 1'b0;
    hzBus.memRegDst  = 5'd5;
    hzBus.memWbEn    = 1'b1;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("memMatchFwd");

    hzBus.forwardEn = 1'b0;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("memMatchNoFwd1");

    hzBus.idSrc1    = 5'd0;
    hzBus.memRegDst = 5'd7;
    hzBus.idSrc2    = 5'd7;
    hzBus.idTwoSrc  = 1'b1;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("memMatchSrc2");

    hzBus.idTwoSrc = 1'b0;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("src2Ignored");

    hzBus.idTwoSrc  = 1'b1;
    hzBus.memRegDst = 5'd0;
    hzBus.idSrc2    = 5'd0;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("reg0Excluded");

    clearInputs();
    hzBus.exeWbEn   = 1'b1;
    hzBus.exeRegDst = 5'd9;
    hzBus.idSrc1    = 5'd9;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("exeAluNoFwd");
    hzBus.forwardEn = 1'b1;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("exeAluFwd");
    hzBus.forwardEn = 1'b0;
    hzBus.exeWbEn   = 1'b0;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("exeNoWb");

    $display("[TB] branch flush priority");
    clearInputs();
    hzBus.forwardEn   = 1'b1;
    loadUse();
    hzBus.branchTaken = 1'b1;
    applyStimulus(C_FLUSH, RUN, 1'b0); checkOutput("flushBeatsHazard");

    $display("[TB] memory wait");
    clearInputs();
    hzBus.forwardEn = 1'b1;
    loadUse();
    hzBus.memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_FRZ, MEM_WAIT, 1'b0); checkOutput("waitFreeze");
    end
    hzBus.memReady = 1'b1;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("waitReadyHazard");

    clearInputs();
    hzBus.memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_FRZ, MEM_WAIT, 1'b0); checkOutput("wait2Freeze");
    end
    hzBus.memReq = 1'b0;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("wait2ReqDrop");

    hzBus.memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_FRZ, MEM_WAIT, 1'b0); checkOutput("wait3Freeze");
    end
    hzBus.memReady = 1'b1;
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("readyWinsTimeout");

    $display("[TB] memory timeout");
    clearInputs();
    hzBus.memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_FRZ, MEM_WAIT, 1'b0); checkOutput("toWait");
    end
    applyStimulus(C_FRZ, ERROR, 1'b1); checkOutput("toEnterError");
    hzBus.memReq      = 1'b0;
    hzBus.forwardEn   = 1'b1;
    loadUse();
    hzBus.branchTaken = 1'b1;
    applyStimulus(C_FRZ, ERROR, 1'b1); checkOutput("errorSticky");

    #2;
    rst_n = 1'b0;
    hzBus.memReq = 1'b1;
    #1;
    checkVal("rstMid.ctrl", 16'(ctrlObs), 16'(C_NONE));
    checkVal("rstMid.state", 16'(hzBus.state), 16'(RUN));
    checkVal("rstMid.mto", 16'(hzBus.memTimeout), 16'd0);
    checkVal("rstMid.flush", hzBus.flushCount, 16'd0);
    checkVal("rstMid.stall", hzBus.stallCycles, 16'd0);
    expStall = 16'd0;
    expFlush = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    clearInputs();
    applyStimulus(C_NONE, RUN, 1'b0); checkOutput("afterReset");

    $display("[TB] counter saturation");
    hzBus.exeWbEn   = 1'b1;
    hzBus.exeRegDst = 5'd9;
    hzBus.idSrc1    = 5'd9;
    repeat (65537) @(posedge clk);
    #1;
    checkVal("satReached", hzBus.stallCycles, 16'hFFFF);
    @(negedge clk);
    expStall = 16'hFFFF;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("satHold");
    hzBus.cntClr = 1'b1;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("clrBeatsInc");
    hzBus.cntClr = 1'b0;
    applyStimulus(C_STALL, RUN, 1'b0); checkOutput("countAfterClr");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
